rdmx_tx_sequencer: RTL and testbench
====================================

RDMX_TX_SEQUENCER -- requirements
Module: rdmx_tx_sequencer

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD, default 8192, the largest accepted payload length in bytes.
REQ-002 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-003 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports req_tvalid (input, 1), req_tready (output, 1), req_addr (input, 64: RDMX target address) and req_len (input, 16: payload bytes), forming the packet-request handshake.
REQ-005 SHALL have ports axis_in_tdata (input, 512), axis_in_tvalid (input, 1) and axis_in_tready (output, 1), carrying the payload stream as little-endian 64-byte beats.
REQ-006 SHALL have ports axis_out_tdata (output, 512), axis_out_tkeep (output, 64), axis_out_tlast (output, 1), axis_out_tvalid (output, 1) and axis_out_tready (input, 1), carrying the framed packet.
REQ-007 SHALL have port seq_num, output, 16 bits: the sequence number for the next packet.
REQ-008 SHALL have port pkt_count, output, 32 bits: the number of packets completed.
REQ-009 SHALL have port err_len, output, 1 bit: a one-cycle pulse when a request is rejected.

Function
REQ-010 SHALL implement FSM states IDLE, HDR and DATA.
REQ-011 SHALL drive req_tready=1 only in IDLE.
REQ-012 SHALL, on a request handshake in IDLE, latch req_addr and req_len, compute beats = ceil(req_len/64), and enter HDR on the next cycle.
REQ-013 SHALL treat req_len=0 or req_len>MAX_PAYLOAD as follows: consume the request, pulse err_len for 1 cycle, remain in IDLE, and emit nothing.
REQ-014 SHALL, in HDR, assert axis_out_tvalid with the 64-byte little-endian RDMX header (Ethernet/IPv4/UDP/RDMX) built from the latched address, latched length and the current seq_num; tkeep=all ones; tlast=0.
REQ-015 SHALL hold the header beat stable until axis_out_tready=1, then enter DATA.
REQ-016 SHALL compute the IPv4 length as 50+len and the UDP length as 30+len, both modulo 2^16.
REQ-017 SHALL compute the IPv4 checksum as a one's-complement fold of a 32-bit sum.
REQ-018 SHALL, in DATA, pass payload through combinationally: axis_out_tdata=axis_in_tdata, axis_out_tvalid=axis_in_tvalid, axis_in_tready=axis_out_tready; it adds no register stage.
REQ-019 SHALL hold axis_in_tready=0 outside DATA.
REQ-020 SHALL count beats down on each output handshake in DATA.
REQ-021 SHALL, on the final beat, drive tlast=1 and tkeep equal to a mask of the low (len mod 64) bytes, or all ones when that value is 0.
REQ-022 SHALL drive tkeep=all ones on all non-final beats.
REQ-023 SHALL, on the final-beat handshake, increment seq_num (wrapping FFFF->0000), increment pkt_count (wrapping), and return to IDLE.
REQ-024 SHALL allow the earliest next request handshake on the cycle after return to IDLE; the back-to-back packet overhead is exactly 1 idle cycle plus 1 header beat.
REQ-025 SHALL ignore axis_in_tvalid outside DATA and stall indefinitely on backpressure without dropping or duplicating beats.

Reset
REQ-026 SHALL, on resetn=0, immediately force the FSM to IDLE and set seq_num=0, pkt_count=0, err_len=0, axis_out_tvalid=0, axis_in_tready=0 and req_tready=0.
REQ-027 SHALL set req_tready=1 on the first clock after resetn deasserts.
REQ-028 SHALL abandon any packet in flight when reset is asserted mid-packet, with no tlast emitted.

Structure
REQ-029 SHALL take the following from shared package rdmx_pkg: header length constants (IP 20, UDP 8, RDMX 22), UDP ports (1000, 32002), MAC/IP constants, RDMX magic 16'h0122, and the FSM state enum.
REQ-030 SHALL build the header in one combinational sub-module, rdmx_hdr_build, with inputs target_addr, payload_length and seq_num and a 512-bit little-endian header output.

Verification
REQ-031 SHALL cover: addr=64'h1000, len=128, downstream always ready -> header beat (seq 0, IP length 178, UDP length 158), then 2 payload beats, tlast on beat 2 with tkeep all ones; seq_num becomes 1.
REQ-032 SHALL cover: len=100 -> 1 header beat plus 2 payload beats; final tkeep=64'h0000_000F_FFFF_FFFF.
REQ-033 SHALL cover: len=0, then len=MAX_PAYLOAD+1 -> 2 err_len pulses, no output, seq_num unchanged.
REQ-034 SHALL cover: random axis_out_tready (50%) and random axis_in_tvalid -> payload matches input in order; header held stable while stalled.
REQ-035 SHALL cover: preloaded seq_num=16'hFFFF after 65535 packets (or forced) -> next header carries FFFF; seq_num then reads 0000.
REQ-036 SHALL cover: resetn asserted during the 2nd payload beat -> outputs drop within the same cycle; the next request produces a header with seq 0.

Source files
------------

// File: rtl/rdmx_pkg.sv
// Shared RDMX constants, the sequencer state type and the IPv4 checksum fold.
package rdmx_pkg;

   localparam int unsigned ETH_HDR_LEN  = 14;
   localparam int unsigned IP_HDR_LEN   = 20;
   localparam int unsigned UDP_HDR_LEN  = 8;
   localparam int unsigned RDMX_HDR_LEN = 22;
   localparam int unsigned HDR_BYTES    = ETH_HDR_LEN + IP_HDR_LEN + UDP_HDR_LEN + RDMX_HDR_LEN;

   localparam logic [15:0] IP_LEN_BASE  = 16'(IP_HDR_LEN + UDP_HDR_LEN + RDMX_HDR_LEN);
   localparam logic [15:0] UDP_LEN_BASE = 16'(UDP_HDR_LEN + RDMX_HDR_LEN);

   localparam logic [15:0] UDP_SRC_PORT   = 16'd1000;
   localparam logic [15:0] UDP_DST_PORT   = 16'd32002;
   localparam logic [47:0] MAC_DST        = 48'h02_00_00_00_00_01;
   localparam logic [47:0] MAC_SRC        = 48'h02_00_00_00_00_02;
   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [31:0] IP_SRC         = 32'h0A00_0001;
   localparam logic [31:0] IP_DST         = 32'h0A00_0002;
   localparam logic [7:0]  IP_TTL         = 8'd64;
   localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
   localparam logic [15:0] RDMX_MAGIC     = 16'h0122;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2
   } state_e;

   // Two folds are enough to absorb every carry of a 32-bit word sum.
   function automatic logic [15:0] csum_fold(input logic [31:0] sum);
      logic [31:0] s;
      s = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
      s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
      return ~s[15:0];
   endfunction

endpackage

// File: rtl/rdmx_hdr_build.sv
// Combinational Ethernet/IPv4/UDP/RDMX header, laid out little-endian (byte 0 in bits 7:0).
module rdmx_hdr_build
   import rdmx_pkg::*;
(
   input  logic [63:0]  target_addr,
   input  logic [15:0]  payload_length,
   input  logic [15:0]  seq_num,
   output logic [511:0] hdr_data
);

   logic [15:0]              ip_len;
   logic [15:0]              udp_len;
   logic [31:0]              csum_sum;
   logic [15:0]              ip_csum;
   logic [8*HDR_BYTES-1:0]   hdr_be;

   assign ip_len  = IP_LEN_BASE + payload_length;
   assign udp_len = UDP_LEN_BASE + payload_length;

   // IPv4 words with the checksum field taken as zero; identification is always zero
   assign csum_sum = 32'h0000_4500 + 32'(ip_len) + 32'h0000_4000 + 32'({IP_TTL, IP_PROTO_UDP})
                   + 32'(IP_SRC[31:16]) + 32'(IP_SRC[15:0]) + 32'(IP_DST[31:16]) + 32'(IP_DST[15:0]);
   assign ip_csum  = csum_fold(csum_sum);

   assign hdr_be = {MAC_DST, MAC_SRC, ETHERTYPE_IPV4,
                    8'h45, 8'h00, ip_len, 16'h0000, 16'h4000, IP_TTL, IP_PROTO_UDP, ip_csum,
                    IP_SRC, IP_DST,
                    UDP_SRC_PORT, UDP_DST_PORT, udp_len, 16'h0000,
                    RDMX_MAGIC, seq_num, target_addr, payload_length, 64'h0};

   always_comb begin
      hdr_data = '0;
      for (int i = 0; i < HDR_BYTES; i++) begin
         hdr_data[8*i +: 8] = hdr_be[8*HDR_BYTES-1-8*i -: 8];
      end
   end

endmodule

// File: rtl/rdmx_tx_sequencer.sv
// RDMX transmit sequencer: takes a packet request, emits one header beat, then passes
// the payload stream through with tkeep/tlast framing on the final beat.
//
// state | meaning
// IDLE  | waiting for a request; bad lengths are consumed and flagged on err_len
// HDR   | header beat held on axis_out until accepted
// DATA  | payload pass-through, beat counter runs down to the final beat
module rdmx_tx_sequencer
   import rdmx_pkg::*;
#(
   parameter int unsigned MAX_PAYLOAD = 8192
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         req_tvalid,
   output logic         req_tready,
   input  logic [63:0]  req_addr,
   input  logic [15:0]  req_len,
   input  logic [511:0] axis_in_tdata,
   input  logic         axis_in_tvalid,
   output logic         axis_in_tready,
   output logic [511:0] axis_out_tdata,
   output logic [63:0]  axis_out_tkeep,
   output logic         axis_out_tlast,
   output logic         axis_out_tvalid,
   input  logic         axis_out_tready,
   output logic [15:0]  seq_num,
   output logic [31:0]  pkt_count,
   output logic         err_len
);

   state_e       state_q, state_d;
   logic [63:0]  addr_q, addr_d;
   logic [15:0]  len_q, len_d;
   logic [10:0]  beats_q, beats_d;
   logic [15:0]  seq_q, seq_d;
   logic [31:0]  pkt_q, pkt_d;
   logic         err_q, err_d;
   logic         armed_q;

   logic [511:0] hdr_data;
   logic [10:0]  req_beats;
   logic         len_bad;
   logic         final_beat;
   logic [63:0]  keep_last;

   rdmx_hdr_build u_hdr_build (
      .target_addr    (addr_q),
      .payload_length (len_q),
      .seq_num        (seq_q),
      .hdr_data       (hdr_data)
   );

   assign req_beats  = 11'(({1'b0, req_len} + 17'd63) >> 6);
   assign len_bad    = (req_len == 16'd0) || ({16'h0, req_len} > MAX_PAYLOAD);
   assign final_beat = (beats_q == 11'd1);
   assign keep_last  = (len_q[5:0] == 6'd0) ? '1 : ((64'd1 << len_q[5:0]) - 64'd1);

   assign seq_num   = seq_q;
   assign pkt_count = pkt_q;
   assign err_len   = err_q;

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      len_d           = len_q;
      beats_d         = beats_q;
      seq_d           = seq_q;
      pkt_d           = pkt_q;
      err_d           = 1'b0;
      req_tready      = 1'b0;
      axis_in_tready  = 1'b0;
      axis_out_tvalid = 1'b0;
      axis_out_tdata  = '0;
      axis_out_tkeep  = '0;
      axis_out_tlast  = 1'b0;
      unique case (state_q)
         IDLE: begin
            // armed_q keeps req_tready low until the first clock after reset release
            req_tready = armed_q;
            if (req_tvalid && armed_q) begin
               if (len_bad) begin
                  err_d = 1'b1;
               end else begin
                  addr_d  = req_addr;
                  len_d   = req_len;
                  beats_d = req_beats;
                  state_d = HDR;
               end
            end
         end
         HDR: begin
            axis_out_tvalid = 1'b1;
            axis_out_tdata  = hdr_data;
            axis_out_tkeep  = '1;
            if (axis_out_tready) state_d = DATA;
         end
         DATA: begin
            axis_out_tdata  = axis_in_tdata;
            axis_out_tvalid = axis_in_tvalid;
            axis_in_tready  = axis_out_tready;
            axis_out_tkeep  = final_beat ? keep_last : '1;
            axis_out_tlast  = final_beat;
            if (axis_in_tvalid && axis_out_tready) begin
               if (final_beat) begin
                  seq_d   = seq_q + 16'd1;
                  pkt_d   = pkt_q + 32'd1;
                  state_d = IDLE;
               end else begin
                  beats_d = beats_q - 11'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         beats_q <= '0;
         seq_q   <= '0;
         pkt_q   <= '0;
         err_q   <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         beats_q <= beats_d;
         seq_q   <= seq_d;
         pkt_q   <= pkt_d;
         err_q   <= err_d;
         armed_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rdmx_tx_sequencer.sv
// Randomized bench for rdmx_tx_sequencer against a byte-level packet model.
module tb_rdmx_tx_sequencer;
   import rdmx_pkg::*;

   localparam int MAXP = 8192;

   logic         clk = 1'b0;
   logic         resetn = 1'b1;
   logic         req_tvalid = 1'b0;
   logic         req_tready;
   logic [63:0]  req_addr = '0;
   logic [15:0]  req_len = '0;
   logic [511:0] axis_in_tdata = '0;
   logic         axis_in_tvalid = 1'b0;
   logic         axis_in_tready;
   logic [511:0] axis_out_tdata;
   logic [63:0]  axis_out_tkeep;
   logic         axis_out_tlast;
   logic         axis_out_tvalid;
   logic         axis_out_tready = 1'b1;
   logic [15:0]  seq_num;
   logic [31:0]  pkt_count;
   logic         err_len;

   int errors = 0;
   int checks = 0;

   logic [511:0] obs_data[$];
   logic [63:0]  obs_keep[$];
   logic         obs_last[$];
   logic [511:0] in_q[$];
   bit           hdr_unstable, in_rdy_early, busy_rdy;
   int           wait_cyc, hdr_lat;
   logic [15:0]  exp_seq = 16'h0;
   logic [31:0]  exp_pkt = 32'h0;

   always #5 clk = ~clk;

   rdmx_tx_sequencer #(.MAX_PAYLOAD(MAXP)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .req_tvalid      (req_tvalid),
      .req_tready      (req_tready),
      .req_addr        (req_addr),
      .req_len         (req_len),
      .axis_in_tdata   (axis_in_tdata),
      .axis_in_tvalid  (axis_in_tvalid),
      .axis_in_tready  (axis_in_tready),
      .axis_out_tdata  (axis_out_tdata),
      .axis_out_tkeep  (axis_out_tkeep),
      .axis_out_tlast  (axis_out_tlast),
      .axis_out_tvalid (axis_out_tvalid),
      .axis_out_tready (axis_out_tready),
      .seq_num         (seq_num),
      .pkt_count       (pkt_count),
      .err_len         (err_len)
   );

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // Header as a byte list in wire order, then packed with byte 0 lowest.
   function automatic logic [511:0] model_hdr(input logic [63:0] addr, input logic [15:0] len,
                                              input logic [15:0] seq);
      logic [7:0]   b[64];
      logic [15:0]  ip_len, udp_len, cs;
      int           sum;
      logic [511:0] r;
      for (int i = 0; i < 64; i++) b[i] = 8'h00;
      for (int i = 0; i < 6; i++) begin
         b[i]     = MAC_DST[8*(5-i) +: 8];
         b[6 + i] = MAC_SRC[8*(5-i) +: 8];
      end
      b[12] = 8'h08;
      ip_len  = 16'(32'(len) + 50);
      udp_len = 16'(32'(len) + 30);
      b[14] = 8'h45; b[16] = ip_len[15:8]; b[17] = ip_len[7:0];
      b[20] = 8'h40; b[22] = 8'd64; b[23] = 8'd17;
      for (int i = 0; i < 4; i++) begin
         b[26 + i] = IP_SRC[8*(3-i) +: 8];
         b[30 + i] = IP_DST[8*(3-i) +: 8];
      end
      sum = 0;
      for (int k = 0; k < 10; k++) sum += 32'({b[14 + 2*k], b[15 + 2*k]});
      while (sum > 32'h0000_FFFF) sum = (sum & 32'h0000_FFFF) + (sum >>> 16);
      cs = ~sum[15:0];
      b[24] = cs[15:8]; b[25] = cs[7:0];
      b[34] = 8'h03; b[35] = 8'hE8; b[36] = 8'h7D; b[37] = 8'h02;
      b[38] = udp_len[15:8]; b[39] = udp_len[7:0];
      b[42] = 8'h01; b[43] = 8'h22; b[44] = seq[15:8]; b[45] = seq[7:0];
      for (int i = 0; i < 8; i++) b[46 + i] = addr[8*(7-i) +: 8];
      b[54] = len[15:8]; b[55] = len[7:0];
      for (int i = 0; i < 64; i++) r[8*i +: 8] = b[i];
      return r;
   endfunction

   function automatic logic [63:0] model_keep(input int len, input int idx);
      int nb, rem;
      logic [63:0] k;
      nb  = (len + 63) / 64;
      rem = len % 64;
      k   = '1;
      if (idx == nb - 1 && rem != 0)
         for (int b = 0; b < 64; b++) k[b] = (b < rem);
      return k;
   endfunction

   task automatic send_packet(input logic [63:0] addr, input logic [15:0] len,
                              input int ready_pct, input int valid_pct, output bit ok);
      int nbeats, cyc;
      logic [511:0] pay, hdr_first;
      bit hdr_seen;
      obs_data.delete(); obs_keep.delete(); obs_last.delete(); in_q.delete();
      hdr_unstable = 0; in_rdy_early = 0; busy_rdy = 0; hdr_seen = 0;
      hdr_lat = -1; wait_cyc = 0; hdr_first = '0; ok = 1'b0;
      nbeats = (32'(len) + 63) / 64;
      req_addr = addr; req_len = len; req_tvalid = 1'b1;
      while (!req_tready && wait_cyc < 50) begin @(posedge clk); #1; wait_cyc++; end
      if (!req_tready) begin req_tvalid = 1'b0; return; end
      @(posedge clk); #1;
      req_tvalid = 1'b0;
      pay = rand512();
      cyc = 0;
      while (obs_data.size() < nbeats + 1 && cyc < 20000) begin
         axis_out_tready = ($urandom_range(99) < ready_pct);
         axis_in_tvalid  = ($urandom_range(99) < valid_pct);
         axis_in_tdata   = pay;
         #3;
         if (req_tready) busy_rdy = 1;
         if (obs_data.size() == 0) begin
            if (axis_in_tready) in_rdy_early = 1;
            if (!hdr_seen && axis_out_tvalid) begin
               hdr_seen = 1; hdr_first = axis_out_tdata; hdr_lat = cyc;
            end else if (hdr_seen && (!axis_out_tvalid || axis_out_tdata !== hdr_first)) begin
               hdr_unstable = 1;
            end
         end
         if (axis_out_tvalid && axis_out_tready) begin
            obs_data.push_back(axis_out_tdata);
            obs_keep.push_back(axis_out_tkeep);
            obs_last.push_back(axis_out_tlast);
         end
         if (axis_in_tvalid && axis_in_tready) begin
            in_q.push_back(pay);
            pay = rand512();
         end
         @(posedge clk); #1;
         cyc++;
      end
      axis_in_tvalid = 1'b0;
      axis_out_tready = 1'b1;
      ok = (obs_data.size() == nbeats + 1) && (in_q.size() == nbeats);
   endtask

   task automatic test_reset();
      #1 resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({req_tready, axis_out_tvalid, axis_in_tready, err_len} !== 4'b0000)
         begin errors++; $display("FAIL reset_ctrl: got %b expected 0000", {req_tready, axis_out_tvalid, axis_in_tready, err_len}); end
      checks++;
      if (seq_num !== 16'h0 || pkt_count !== 32'h0)
         begin errors++; $display("FAIL reset_counts: got seq=%h pkt=%h expected 0/0", seq_num, pkt_count); end
      resetn = 1'b1;
      #2;
      checks++;
      if (req_tready !== 1'b0) begin errors++; $display("FAIL reset_rdy_early: got %b expected 0", req_tready); end
      @(posedge clk); #1;
      checks++;
      if (req_tready !== 1'b1) begin errors++; $display("FAIL reset_rdy_first_clk: got %b expected 1", req_tready); end
   endtask

   task automatic test_basic();
      bit ok;
      logic [511:0] h;
      int sum;
      send_packet(64'h1000, 16'd128, 100, 100, ok);
      checks++;
      if (!ok || obs_data.size() != 3) begin
         errors++; $display("FAIL basic_beats: got %0d expected 3", obs_data.size());
      end else begin
         h = obs_data[0];
         checks++;
         if (h !== model_hdr(64'h1000, 16'd128, 16'h0))
            begin errors++; $display("FAIL basic_hdr: got %h expected %h", h, model_hdr(64'h1000, 16'd128, 16'h0)); end
         checks++;
         if ({h[135:128], h[143:136]} !== 16'd178 || {h[311:304], h[319:312]} !== 16'd158)
            begin errors++; $display("FAIL basic_lengths: got ip=%0d udp=%0d expected 178/158", {h[135:128], h[143:136]}, {h[311:304], h[319:312]}); end
         checks++;
         if ({h[359:352], h[367:360]} !== 16'h0000)
            begin errors++; $display("FAIL basic_hdr_seq: got %h expected 0000", {h[359:352], h[367:360]}); end
         sum = 0;
         for (int k = 0; k < 10; k++) sum += 32'({h[8*(14+2*k) +: 8], h[8*(15+2*k) +: 8]});
         while (sum > 32'h0000_FFFF) sum = (sum & 32'h0000_FFFF) + (sum >>> 16);
         checks++;
         if (sum[15:0] !== 16'hFFFF) begin errors++; $display("FAIL basic_ip_csum: got %h expected ffff", sum[15:0]); end
         checks++;
         if (obs_keep[0] !== '1 || obs_last[0] !== 1'b0)
            begin errors++; $display("FAIL basic_hdr_framing: got keep=%h last=%b expected all-ones/0", obs_keep[0], obs_last[0]); end
         for (int i = 1; i <= 2; i++) begin
            checks++;
            if (obs_data[i] !== in_q[i-1] || obs_keep[i] !== 64'hFFFF_FFFF_FFFF_FFFF || obs_last[i] !== (i == 2))
               begin errors++; $display("FAIL basic_beat%0d: got keep=%h last=%b expected full keep last=%b", i, obs_keep[i], obs_last[i], (i == 2)); end
         end
      end
      exp_seq++; exp_pkt++;
      checks++;
      if (seq_num !== exp_seq || pkt_count !== exp_pkt)
         begin errors++; $display("FAIL basic_seq: got %h/%0d expected %h/%0d", seq_num, pkt_count, exp_seq, exp_pkt); end
   endtask

   task automatic test_partial();
      int lens[4];
      int nb;
      bit ok;
      logic [63:0] addr;
      lens = '{100, 1, 64, MAXP};
      for (int t = 0; t < 4; t++) begin
         addr = {$urandom, $urandom};
         send_packet(addr, 16'(lens[t]), 100, 100, ok);
         nb = (lens[t] + 63) / 64;
         checks++;
         if (!ok || obs_data.size() != nb + 1) begin
            errors++; $display("FAIL partial_beats len=%0d: got %0d expected %0d", lens[t], obs_data.size(), nb + 1);
         end else begin
            checks++;
            if (obs_data[0] !== model_hdr(addr, 16'(lens[t]), exp_seq))
               begin errors++; $display("FAIL partial_hdr len=%0d: got %h expected %h", lens[t], obs_data[0], model_hdr(addr, 16'(lens[t]), exp_seq)); end
            for (int i = 1; i <= nb; i++) begin
               checks++;
               if (obs_data[i] !== in_q[i-1] || obs_keep[i] !== model_keep(lens[t], i - 1) || obs_last[i] !== (i == nb))
                  begin errors++; $display("FAIL partial_beat len=%0d beat=%0d: got keep=%h last=%b expected keep=%h last=%b", lens[t], i, obs_keep[i], obs_last[i], model_keep(lens[t], i - 1), (i == nb)); end
            end
            if (lens[t] == 100) begin
               checks++;
               if (obs_keep[nb] !== 64'h0000_000F_FFFF_FFFF)
                  begin errors++; $display("FAIL partial_keep100: got %h expected 0000000fffffffff", obs_keep[nb]); end
            end
         end
         exp_seq++; exp_pkt++;
         checks++;
         if (seq_num !== exp_seq) begin errors++; $display("FAIL partial_seq: got %h expected %h", seq_num, exp_seq); end
      end
   endtask

   task automatic test_err_len();
      logic [15:0] bad[2];
      int pulses, outv, cyc;
      bad[0] = 16'd0; bad[1] = 16'(MAXP + 1);
      pulses = 0; outv = 0;
      axis_in_tvalid = 1'b1; axis_in_tdata = rand512(); axis_out_tready = 1'b1;
      for (int t = 0; t < 2; t++) begin
         req_len = bad[t]; req_addr = {$urandom, $urandom}; req_tvalid = 1'b1;
         cyc = 0;
         while (!req_tready && cyc < 50) begin @(posedge clk); #1; cyc++; end
         @(posedge clk); #1;
         req_tvalid = 1'b0;
         checks++;
         if (req_tready !== 1'b1) begin errors++; $display("FAIL err_stay_idle len=%0d: got rdy=%b expected 1", bad[t], req_tready); end
         for (int c = 0; c < 4; c++) begin
            if (err_len) pulses++;
            if (axis_out_tvalid) outv++;
            @(posedge clk); #1;
         end
      end
      axis_in_tvalid = 1'b0;
      checks++;
      if (pulses != 2) begin errors++; $display("FAIL err_pulses: got %0d expected 2", pulses); end
      checks++;
      if (outv != 0) begin errors++; $display("FAIL err_no_output: got %0d valid cycles expected 0", outv); end
      checks++;
      if (seq_num !== exp_seq || pkt_count !== exp_pkt)
         begin errors++; $display("FAIL err_seq: got %h/%0d expected %h/%0d", seq_num, pkt_count, exp_seq, exp_pkt); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      send_packet(64'h2000, 16'd64, 100, 100, ok);
      exp_seq++; exp_pkt++;
      checks++;
      if (!ok || hdr_lat != 0) begin errors++; $display("FAIL b2b_first: got ok=%b hdr_lat=%0d expected 1/0", ok, hdr_lat); end
      send_packet(64'h3000, 16'd70, 100, 100, ok);
      exp_seq++; exp_pkt++;
      checks++;
      if (!ok || wait_cyc != 0 || hdr_lat != 0)
         begin errors++; $display("FAIL b2b_gap: got ok=%b wait=%0d hdr_lat=%0d expected 1/0/0", ok, wait_cyc, hdr_lat); end
      checks++;
      if (obs_last.size() == 3 && obs_keep[2] !== model_keep(70, 1))
         begin errors++; $display("FAIL b2b_keep: got %h expected %h", obs_keep[2], model_keep(70, 1)); end
   endtask

   task automatic test_random_stall();
      bit ok;
      int len, nb;
      logic [63:0] addr;
      for (int p = 0; p < 6; p++) begin
         len  = $urandom_range(400, 1);
         addr = {$urandom, $urandom};
         nb   = (len + 63) / 64;
         send_packet(addr, 16'(len), 50, 60, ok);
         checks++;
         if (!ok) begin
            errors++; $display("FAIL rand_count pkt=%0d: got out=%0d in=%0d expected %0d", p, obs_data.size(), in_q.size(), nb + 1);
         end else begin
            checks++;
            if (obs_data[0] !== model_hdr(addr, 16'(len), exp_seq))
               begin errors++; $display("FAIL rand_hdr pkt=%0d: got %h expected %h", p, obs_data[0], model_hdr(addr, 16'(len), exp_seq)); end
            for (int i = 1; i <= nb; i++) begin
               checks++;
               if (obs_data[i] !== in_q[i-1] || obs_keep[i] !== model_keep(len, i - 1) || obs_last[i] !== (i == nb))
                  begin errors++; $display("FAIL rand_beat pkt=%0d beat=%0d: got keep=%h last=%b expected keep=%h last=%b", p, i, obs_keep[i], obs_last[i], model_keep(len, i - 1), (i == nb)); end
            end
         end
         checks++;
         if (hdr_unstable || in_rdy_early || busy_rdy)
            begin errors++; $display("FAIL rand_stall pkt=%0d: got unstable=%b in_rdy=%b req_rdy=%b expected 0/0/0", p, hdr_unstable, in_rdy_early, busy_rdy); end
         exp_seq++; exp_pkt++;
      end
      checks++;
      if (seq_num !== exp_seq || pkt_count !== exp_pkt)
         begin errors++; $display("FAIL rand_seq: got %h/%0d expected %h/%0d", seq_num, pkt_count, exp_seq, exp_pkt); end
   endtask

   task automatic test_seq_wrap();
      bit ok;
      force dut.seq_q = 16'hFFFF;
      @(posedge clk); #1;
      release dut.seq_q;
      exp_seq = 16'hFFFF;
      send_packet(64'h4000, 16'd10, 100, 100, ok);
      checks++;
      if (!ok || obs_data[0] !== model_hdr(64'h4000, 16'd10, 16'hFFFF))
         begin errors++; $display("FAIL wrap_hdr: got %h expected %h", obs_data[0], model_hdr(64'h4000, 16'd10, 16'hFFFF)); end
      exp_seq++; exp_pkt++;
      checks++;
      if (seq_num !== 16'h0000 || pkt_count !== exp_pkt)
         begin errors++; $display("FAIL wrap_seq: got %h/%0d expected 0000/%0d", seq_num, pkt_count, exp_pkt); end
   endtask

   task automatic test_reset_midpacket();
      bit ok;
      int cyc;
      req_addr = 64'hDEAD_BEEF_0000_0040; req_len = 16'd192; req_tvalid = 1'b1;
      axis_out_tready = 1'b1; axis_in_tvalid = 1'b1; axis_in_tdata = rand512();
      cyc = 0;
      while (!req_tready && cyc < 50) begin @(posedge clk); #1; cyc++; end
      @(posedge clk); #1;
      req_tvalid = 1'b0;
      @(posedge clk); #1;
      axis_in_tdata = rand512();
      @(posedge clk); #1;
      axis_in_tdata = rand512();
      #1;
      checks++;
      if (axis_out_tvalid !== 1'b1 || axis_out_tlast !== 1'b0 || axis_in_tready !== 1'b1)
         begin errors++; $display("FAIL mid_beat2: got v=%b l=%b r=%b expected 1/0/1", axis_out_tvalid, axis_out_tlast, axis_in_tready); end
      resetn = 1'b0;
      #1;
      checks++;
      if ({axis_out_tvalid, axis_out_tlast, axis_in_tready, req_tready} !== 4'b0000)
         begin errors++; $display("FAIL mid_reset_drop: got %b expected 0000", {axis_out_tvalid, axis_out_tlast, axis_in_tready, req_tready}); end
      checks++;
      if (seq_num !== 16'h0 || pkt_count !== 32'h0)
         begin errors++; $display("FAIL mid_reset_counts: got %h/%0d expected 0/0", seq_num, pkt_count); end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (axis_out_tvalid !== 1'b0 || axis_out_tlast !== 1'b0)
         begin errors++; $display("FAIL mid_reset_hold: got v=%b l=%b expected 0/0", axis_out_tvalid, axis_out_tlast); end
      axis_in_tvalid = 1'b0;
      resetn = 1'b1;
      exp_seq = 16'h0; exp_pkt = 32'h0;
      send_packet(64'h5000, 16'd50, 100, 100, ok);
      checks++;
      if (!ok || obs_data[0] !== model_hdr(64'h5000, 16'd50, 16'h0))
         begin errors++; $display("FAIL mid_next_hdr: got %h expected %h", obs_data[0], model_hdr(64'h5000, 16'd50, 16'h0)); end
      exp_seq++; exp_pkt++;
      checks++;
      if (seq_num !== exp_seq || pkt_count !== exp_pkt)
         begin errors++; $display("FAIL mid_next_seq: got %h/%0d expected %h/%0d", seq_num, pkt_count, exp_seq, exp_pkt); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_partial();
      test_err_len();
      test_back_to_back();
      test_random_stall();
      test_seq_wrap();
      test_reset_midpacket();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "time limit");
   end

endmodule
